// File: rtl/spi_cmd_ctrl_if.sv
// Bundle of the SPI word, pixel RAM and WS2812 driver signals around spi_cmd_ctrl.
// slave is the controller's view; master is the view of the surrounding system.
interface spi_cmd_ctrl_if;
  logic        mosi_rx;
  logic [23:0] mosi_data;
  logic        miso_tx;
  logic [23:0] miso_data;
  logic        pix_we;
  logic [7:0]  pix_addr;
  logic [23:0] pix_wdata;
  logic [23:0] pix_rdata;
  logic [7:0]  led_count;
  logic        frame_start;
  logic        driver_busy;
  logic        err;

  modport slave (
    input  mosi_rx, mosi_data, pix_rdata, driver_busy,
    output miso_tx, miso_data, pix_we, pix_addr, pix_wdata, led_count, frame_start, err
  );

  modport master (
    output mosi_rx, mosi_data, pix_rdata, driver_busy,
    input  miso_tx, miso_data, pix_we, pix_addr, pix_wdata, led_count, frame_start, err
  );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// Decodes 24-bit SPI command words into pixel RAM writes/reads, LED length updates,
// frame triggers for the WS2812 driver and a status reply word.
module spi_cmd_ctrl (
  input  logic          clk_sb,
  input  logic          reset,
  spi_cmd_ctrl_if.slave bus
);

  localparam logic [7:0] CmdNop    = 8'h00;
  localparam logic [7:0] CmdWrite  = 8'h01;
  localparam logic [7:0] CmdRead   = 8'h02;
  localparam logic [7:0] CmdSetLen = 8'h03;
  localparam logic [7:0] CmdShow   = 8'h04;
  localparam logic [7:0] CmdStatus = 8'h05;

  typedef enum logic [1:0] {StIdle, StWrStream, StRdAddr, StRdData} state_e;

  state_e      state;
  logic [7:0]  addr;
  logic [8:0]  remaining;
  logic        show_pend;
  logic        err_cmd, err_arg, err_ovr;
  logic        err_cmd_d, err_arg_d, err_ovr_d;

  logic [7:0]  cmd;
  logic [15:0] arg;
  logic        hdr, is_show, is_status, stat_ok, stat_clash, drop, cmd_known;

  assign cmd        = bus.mosi_data[23:16];
  assign arg        = bus.mosi_data[15:0];
  assign hdr        = bus.mosi_rx && (state == StIdle);
  assign is_show    = hdr && (cmd == CmdShow);
  assign is_status  = hdr && (cmd == CmdStatus);
  // A STATUS landing while a read reply is on miso_tx would pulse miso_tx twice in a row.
  assign stat_clash = is_status && bus.miso_tx;
  assign stat_ok    = is_status && !bus.miso_tx;
  assign drop       = (bus.mosi_rx && (state == StRdAddr || state == StRdData)) || stat_clash;
  assign cmd_known  = (cmd == CmdNop) || (cmd == CmdWrite) || (cmd == CmdRead) ||
                      (cmd == CmdSetLen) || (cmd == CmdShow) || (cmd == CmdStatus);

  always_comb begin
    err_cmd_d = err_cmd;
    err_arg_d = err_arg;
    err_ovr_d = err_ovr;
    if (stat_ok) begin
      err_cmd_d = 1'b0;
      err_arg_d = 1'b0;
      err_ovr_d = 1'b0;
    end
    if (hdr && !cmd_known) err_cmd_d = 1'b1;
    if (hdr && (cmd == CmdSetLen) && (arg[7:0] == 8'h00)) err_arg_d = 1'b1;
    if (drop) err_ovr_d = 1'b1;
  end

  always_ff @(posedge clk_sb) begin
    if (reset) begin
      state           <= StIdle;
      addr            <= 8'h00;
      remaining       <= 9'd0;
      show_pend       <= 1'b0;
      err_cmd         <= 1'b0;
      err_arg         <= 1'b0;
      err_ovr         <= 1'b0;
      bus.err         <= 1'b0;
      bus.led_count   <= 8'd60;
      bus.miso_data   <= 24'h0;
      bus.miso_tx     <= 1'b0;
      bus.pix_we      <= 1'b0;
      bus.pix_addr    <= 8'h00;
      bus.pix_wdata   <= 24'h0;
      bus.frame_start <= 1'b0;
    end else begin
      bus.pix_we      <= 1'b0;
      bus.miso_tx     <= 1'b0;
      // A busy driver defers the frame; repeated SHOWs collapse into one pending request.
      bus.frame_start <= !bus.driver_busy && (show_pend || is_show);
      show_pend       <= bus.driver_busy && (show_pend || is_show);
      err_cmd         <= err_cmd_d;
      err_arg         <= err_arg_d;
      err_ovr         <= err_ovr_d;
      bus.err         <= err_cmd_d | err_arg_d | err_ovr_d;

      if (stat_ok) begin
        bus.miso_data <= {8'hA5, 4'b0, show_pend, err_ovr, err_arg, err_cmd, bus.led_count};
        bus.miso_tx   <= 1'b1;
      end

      unique case (state)
        StIdle: begin
          if (bus.mosi_rx) begin
            case (cmd)
              CmdWrite: begin
                addr      <= arg[7:0];
                remaining <= {1'b0, arg[15:8]} + 9'd1;
                state     <= StWrStream;
              end
              CmdRead: begin
                addr         <= arg[7:0];
                bus.pix_addr <= arg[7:0];
                state        <= StRdAddr;
              end
              CmdSetLen: begin
                if (arg[7:0] != 8'h00) bus.led_count <= arg[7:0];
              end
              default: ;
            endcase
          end
        end
        StWrStream: begin
          if (bus.mosi_rx) begin
            bus.pix_we    <= 1'b1;
            bus.pix_wdata <= bus.mosi_data;
            bus.pix_addr  <= addr;
            addr          <= addr + 8'd1;
            remaining     <= remaining - 9'd1;
            if (remaining == 9'd1) state <= StIdle;
          end
        end
        StRdAddr: state <= StRdData;
        StRdData: begin
          bus.miso_data <= bus.pix_rdata;
          bus.miso_tx   <= 1'b1;
          state         <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Random and directed command streams for spi_cmd_ctrl, scored against a word-level
// reference model; a negedge monitor pops expected events as the DUT produces them.
module tb_spi_cmd_ctrl;

  logic clk_sb = 1'b0;
  logic reset  = 1'b1;
  logic ram_clr = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_sb = ~clk_sb;
  always @(posedge clk_sb) cyc <= cyc + 1;

  spi_cmd_ctrl_if bus ();

  spi_cmd_ctrl dut (
    .clk_sb (clk_sb),
    .reset  (reset),
    .bus    (bus)
  );

  function automatic logic [23:0] pat(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A};
  endfunction

  // Pixel RAM with one cycle of read latency.
  logic [23:0] ram [256];
  always @(posedge clk_sb) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= pat(8'(i));
    end else if (bus.pix_we) begin
      ram[bus.pix_addr] <= bus.pix_wdata;
    end
    bus.pix_rdata <= ram[bus.pix_addr];
  end

  typedef struct {
    int          at;
    logic [31:0] v;
  } ev_t;

  ev_t miso_q[$];
  ev_t wr_q[$];
  ev_t fr_q[$];
  ev_t st_q[$];

  function automatic ev_t mk(input int at, input logic [31:0] v);
    ev_t e;
    e.at = at;
    e.v  = v;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: one call per clock edge k with the inputs sampled at that edge.
  logic [23:0] mem [256];
  int          m_wr_left, m_rd_end, m_last_miso;
  logic [7:0]  m_addr, m_led;
  bit          m_pend, m_ecmd, m_earg, m_eovr;

  task automatic model_edge(input int k, input bit rst, input bit rx, input logic [23:0] d,
                            input bit busy);
    bit          show;
    logic [7:0]  c;
    logic [15:0] a;
    show = 1'b0;
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] = pat(8'(i));
      m_wr_left = 0; m_rd_end = -10; m_last_miso = -10;
      m_addr = 8'h00; m_led = 8'd60;
      m_pend = 0; m_ecmd = 0; m_earg = 0; m_eovr = 0;
      while (miso_q.size() > 0 && miso_q[$].at >= k) void'(miso_q.pop_back());
      while (wr_q.size() > 0 && wr_q[$].at >= k) void'(wr_q.pop_back());
      while (fr_q.size() > 0 && fr_q[$].at >= k) void'(fr_q.pop_back());
      st_q.push_back(mk(k, {23'd0, 1'b0, 8'd60}));
      return;
    end
    if (rx) begin
      c = d[23:16];
      a = d[15:0];
      if (k <= m_rd_end) begin
        m_eovr = 1;
      end else if (m_wr_left > 0) begin
        wr_q.push_back(mk(k, {m_addr, d}));
        mem[m_addr] = d;
        m_addr = m_addr + 8'd1;
        m_wr_left--;
      end else begin
        case (c)
          8'h00: ;
          8'h01: begin m_addr = a[7:0]; m_wr_left = int'(a[15:8]) + 1; end
          8'h02: begin
            m_addr = a[7:0];
            miso_q.push_back(mk(k + 2, {8'h00, mem[m_addr]}));
            m_rd_end = k + 2;
            m_last_miso = k + 2;
          end
          8'h03: if (a[7:0] != 8'h00) m_led = a[7:0]; else m_earg = 1;
          8'h04: show = 1;
          8'h05: begin
            if (m_last_miso == k - 1) begin
              m_eovr = 1;
            end else begin
              miso_q.push_back(mk(k, {8'h00, 8'hA5, 4'h0, m_pend, m_eovr, m_earg, m_ecmd,
                                      m_led}));
              m_last_miso = k;
              m_ecmd = 0; m_earg = 0; m_eovr = 0;
            end
          end
          default: m_ecmd = 1;
        endcase
      end
    end
    if (!busy && (m_pend || show)) begin
      fr_q.push_back(mk(k, 32'd0));
      m_pend = 0;
    end else if (busy) begin
      m_pend = m_pend | show;
    end
    st_q.push_back(mk(k, {23'd0, m_ecmd | m_earg | m_eovr, m_led}));
  endtask

  // Sets inputs for the coming edge, records model expectations, returns after that edge.
  task automatic step(input bit rst, input bit rx, input logic [23:0] d, input bit busy);
    reset           = rst;
    ram_clr         = rst;
    bus.mosi_rx     = rx;
    bus.mosi_data   = d;
    bus.driver_busy = busy;
    model_edge(cyc + 1, rst, rx, d, busy);
    @(negedge clk_sb);
  endtask

  always @(negedge clk_sb) begin
    if (cyc > 0) begin
      ev_t e;
      if (bus.miso_tx) begin
        if (miso_q.size() == 0) check("miso_tx spurious", 32'(bus.miso_tx), 32'd0);
        else begin
          e = miso_q.pop_front();
          check("miso_tx timing", 32'(cyc), 32'(e.at));
          check("miso_data", 32'(bus.miso_data), e.v);
        end
      end else begin
        while (miso_q.size() > 0 && miso_q[0].at <= cyc) begin
          void'(miso_q.pop_front());
          check("miso_tx missing", 32'(bus.miso_tx), 32'd1);
        end
      end
      if (bus.pix_we) begin
        if (wr_q.size() == 0) check("pix_we spurious", 32'(bus.pix_we), 32'd0);
        else begin
          e = wr_q.pop_front();
          check("pix_we timing", 32'(cyc), 32'(e.at));
          check("pix_write addr/data", {bus.pix_addr, bus.pix_wdata}, e.v);
        end
      end else begin
        while (wr_q.size() > 0 && wr_q[0].at <= cyc) begin
          void'(wr_q.pop_front());
          check("pix_we missing", 32'(bus.pix_we), 32'd1);
        end
      end
      if (bus.frame_start) begin
        if (fr_q.size() == 0) check("frame_start spurious", 32'(bus.frame_start), 32'd0);
        else begin
          e = fr_q.pop_front();
          check("frame_start timing", 32'(cyc), 32'(e.at));
        end
      end else begin
        while (fr_q.size() > 0 && fr_q[0].at <= cyc) begin
          void'(fr_q.pop_front());
          check("frame_start missing", 32'(bus.frame_start), 32'd1);
        end
      end
      while (st_q.size() > 0 && st_q[0].at < cyc) void'(st_q.pop_front());
      if (st_q.size() > 0 && st_q[0].at == cyc) begin
        e = st_q.pop_front();
        check("err", 32'(bus.err), 32'(e.v[8]));
        check("led_count", 32'(bus.led_count), 32'(e.v[7:0]));
      end
    end
  end

  initial begin
    bit          busy;
    logic [23:0] w;
    busy = 1'b0;
    bus.pix_rdata = 24'h0;

    repeat (3) step(1, 0, 24'h0, 0);
    check("reset miso_data", 32'(bus.miso_data), 32'h0);
    check("reset miso_tx", 32'(bus.miso_tx), 32'h0);
    check("reset pix_we", 32'(bus.pix_we), 32'h0);
    check("reset frame_start", 32'(bus.frame_start), 32'h0);
    check("reset led_count", 32'(bus.led_count), 32'd60);
    check("reset err", 32'(bus.err), 32'h0);

    // Error flags and status clear-on-read.
    step(0, 1, 24'h030000, 0);
    step(0, 1, 24'h7E0000, 0);
    check("err after bad cmd", 32'(bus.err), 32'd1);
    step(0, 1, 24'h050000, 0);
    check("status 1 word", 32'(bus.miso_data), 32'hA5033C);
    step(0, 0, 24'h0, 0);
    step(0, 1, 24'h050000, 0);
    check("status 2 word", 32'(bus.miso_data), 32'hA5003C);
    check("err after status", 32'(bus.err), 32'd0);

    // Write stream wrapping 0xFF -> 0x00, then a header.
    step(0, 1, 24'h0102FE, 0);
    step(0, 0, 24'h0, 0);
    step(0, 1, 24'h111111, 0);
    step(0, 1, 24'h222222, 0);
    step(0, 1, 24'h333333, 0);
    check("wrap write addr", 32'(bus.pix_addr), 32'h00);
    check("wrap write data", 32'(bus.pix_wdata), 32'h333333);
    step(0, 1, 24'h050000, 0);
    check("header after stream", 32'(bus.miso_tx), 32'd1);
    step(0, 0, 24'h0, 0);

    // Read back a written word.
    step(0, 1, 24'h010010, 0);
    step(0, 1, 24'hABCDEF, 0);
    step(0, 1, 24'h020010, 0);
    step(0, 0, 24'h0, 0);
    check("read early miso_tx", 32'(bus.miso_tx), 32'd0);
    step(0, 0, 24'h0, 0);
    check("read miso_tx", 32'(bus.miso_tx), 32'd1);
    check("read data", 32'(bus.miso_data), 32'hABCDEF);

    // Overrun during a read.
    step(0, 1, 24'h020010, 0);
    step(0, 1, 24'h000000, 0);
    step(0, 0, 24'h0, 0);
    check("overrun read data", 32'(bus.miso_data), 32'hABCDEF);
    check("overrun err", 32'(bus.err), 32'd1);
    step(0, 0, 24'h0, 0);
    step(0, 1, 24'h050000, 0);
    check("overrun status", 32'(bus.miso_data), 32'hA5043C);

    // Two SHOWs while busy merge into one frame when busy drops.
    step(0, 0, 24'h0, 1);
    step(0, 1, 24'h040000, 1);
    step(0, 0, 24'h0, 1);
    step(0, 1, 24'h040000, 1);
    step(0, 0, 24'h0, 1);
    check("no frame while busy", 32'(bus.frame_start), 32'd0);
    step(0, 0, 24'h0, 0);
    check("frame on busy fall", 32'(bus.frame_start), 32'd1);
    step(0, 0, 24'h0, 0);
    check("single frame", 32'(bus.frame_start), 32'd0);

    // Reset in the middle of a stream.
    step(0, 1, 24'h010420, 0);
    step(0, 1, 24'h0A0A0A, 0);
    step(0, 1, 24'h0B0B0B, 0);
    step(1, 0, 24'h0, 0);
    step(0, 0, 24'h0, 0);
    step(0, 1, 24'h050000, 0);
    check("status after reset", 32'(bus.miso_data), 32'hA5003C);
    repeat (3) step(0, 0, 24'h0, 0);

    repeat (400) begin
      if ($urandom_range(0, 9) == 0) busy = ~busy;
      case ($urandom_range(0, 9))
        0: w = 24'h000000 | 24'($urandom_range(0, 65535));
        1: w = {8'h01, 8'($urandom_range(0, 5)), 8'($urandom)};
        2: w = {8'h02, 8'($urandom), 8'($urandom)};
        3: w = {8'h03, 8'($urandom), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom)};
        4: w = {8'h04, 16'($urandom)};
        5: w = {8'h05, 16'($urandom)};
        default: w = 24'($urandom);
      endcase
      if ($urandom_range(0, 59) == 0) step(1, 0, 24'h0, busy);
      else step(0, 1, w, busy);
      repeat ($urandom_range(0, 2)) step(0, 0, 24'($urandom), busy);
    end

    repeat (10) step(0, 0, 24'h0, 0);
    check("miso queue drained", 32'(miso_q.size()), 32'd0);
    check("write queue drained", 32'(wr_q.size()), 32'd0);
    check("frame queue drained", 32'(fr_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_cmd_ctrl.md
SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

Interface
REQ-001 clk_sb  input  1  system clock; all logic rising-edge on clk_sb.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 mosi_rx  input  1  one-cycle pulse: a 24-bit SPI word has completed.
REQ-004 mosi_data  input  24  received word; valid while mosi_rx=1.
REQ-005 miso_tx  output  1  one-cycle pulse: load miso_data as the next SPI reply word.
REQ-006 miso_data  output  24  reply word; held stable after miso_tx until the next miso_tx.
REQ-007 pix_we  output  1  pixel RAM write strobe, one cycle per write.
REQ-008 pix_addr  output  8  pixel RAM address for both read and write.
REQ-009 pix_wdata  output  24  pixel RAM write data, GRB.
REQ-010 pix_rdata  input  24  pixel RAM read data; valid one cycle after pix_addr is presented.
REQ-011 led_count  output  8  number of LEDs the WS2812 driver shall send.
REQ-012 frame_start  output  1  one-cycle pulse: WS2812 driver starts a frame.
REQ-013 driver_busy  input  1  WS2812 driver frame in progress.
REQ-014 err  output  1  OR of the sticky error flags.

Function
REQ-015 Header word decode: cmd=mosi_data[23:16], arg=mosi_data[15:0]; header words are accepted only in state IDLE.
REQ-016 States: IDLE, WR_STREAM, RD_ADDR, RD_DATA.
REQ-017 cmd 0x01 WRITE: addr<=arg[7:0], remaining<=arg[15:8]+1 (9-bit, range 1..256); transition to WR_STREAM.
REQ-018 In WR_STREAM, each mosi_rx causes: pix_we=1 for one cycle, pix_wdata=mosi_data, pix_addr=addr, addr<=addr+1 (mod 256, 0xFF wraps to 0x00), remaining<=remaining-1.
REQ-019 In WR_STREAM, the write that brings remaining to 0 returns the FSM to IDLE in the same cycle; the following word is then decoded as a header.
REQ-020 cmd 0x02 READ: addr<=arg[7:0]; IDLE->RD_ADDR, then RD_DATA, then IDLE.
REQ-021 In RD_ADDR, pix_addr=addr is driven to the RAM.
REQ-022 In RD_DATA, miso_data<=pix_rdata and miso_tx pulses, exactly 2 cycles after the header's mosi_rx.
REQ-023 cmd 0x03 SETLEN: arg[7:0]!=0 sets led_count<=arg[7:0]; arg[7:0]==0 leaves led_count unchanged and sets err_arg.
REQ-024 cmd 0x04 SHOW with driver_busy=0 and no show already pending: frame_start pulses the cycle after mosi_rx.
REQ-025 cmd 0x04 SHOW with driver_busy=1: show_pend<=1; frame_start pulses in the first cycle driver_busy is observed 0; show_pend then clears.
REQ-026 A further SHOW while show_pend=1 is merged into the pending show; at most one frame_start results.
REQ-027 cmd 0x05 STATUS: miso_data<={8'hA5, 4'b0, show_pend, err_ovr, err_arg, err_cmd, led_count}; miso_tx pulses the cycle after mosi_rx.
REQ-028 STATUS clears err_cmd, err_arg and err_ovr in the same cycle the status word is captured; the captured word shows the pre-clear values.
REQ-029 cmd 0x00 NOP: no action.
REQ-030 Any other cmd value: no action other than setting err_cmd.
REQ-031 mosi_rx arriving in RD_ADDR or RD_DATA is dropped and sets err_ovr; the FSM completes the read normally.
REQ-032 pix_we is never asserted outside WR_STREAM; miso_tx is never asserted on consecutive cycles.
REQ-033 err = err_cmd | err_arg | err_ovr, registered.

Reset
REQ-034 While reset=1 the following hold at the next clk_sb edge: state=IDLE, addr=0, remaining=0, led_count=8'd60, show_pend=0, all error flags=0, miso_data=0, and miso_tx=pix_we=frame_start=0.
REQ-035 Reset asserted mid-WR_STREAM or mid-read aborts the operation: no further pix_we or miso_tx; the next word after reset is decoded as a header.

Verification
REQ-036 Header 0x01_02_FE, then words 0x111111, 0x222222, 0x333333 -> RAM writes at 0xFE, 0xFF, 0x00 with pix_we pulses of one cycle each; the fourth word is decoded as a header.
REQ-037 RAM[0x10]=0xABCDEF, header 0x02_00_10 -> miso_tx pulses 2 cycles after mosi_rx with miso_data=0xABCDEF.
REQ-038 driver_busy=1, two SHOW headers, then driver_busy falls -> exactly one frame_start pulse, in the first cycle driver_busy=0.
REQ-039 SETLEN 0x03_00_00, then cmd 0x7E, then STATUS -> miso_data=0xA5_0_3_3C (err_arg=1, err_cmd=1, led_count=60); a second STATUS returns 0xA5_0_0_3C and err=0.
REQ-040 READ header followed by mosi_rx one cycle later -> read completes with correct data, err_ovr=1.
REQ-041 Reset pulse after 2 of 5 stream words -> no further pix_we; the next word 0x05_0000 returns a STATUS word with led_count=0x3C.
